// File: rtl/rua_run_ctrl.sv
// Run controller for the rua core: holds the core in reset and streams a byte image into RAM.
// It then runs the core until a tohost store or cycle-budget expiry and latches the result.
module rua_run_ctrl #(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter int unsigned             MEM_BYTES   = 5300,
    parameter int unsigned             MAX_CYCLES  = 100,
    parameter logic [ADDR_WIDTH-1:0]   TOHOST_ADDR = ADDR_WIDTH'(32'h0000_1000),
    parameter int unsigned             CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  cpu_rst,
    input  logic                  mon_we,
    input  logic [ADDR_WIDTH-1:0] mon_addr,
    input  logic [DATA_WIDTH-1:0] mon_wdata,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic                  load_err,
    output logic [DATA_WIDTH-1:0] exit_code,
    output logic [CNT_WIDTH-1:0]  cycles
);

    localparam int unsigned PTR_W = $clog2(MEM_BYTES + 1);
    localparam int unsigned BUD_W = $clog2(MAX_CYCLES + 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(MEM_BYTES);
    localparam logic [BUD_W-1:0] BUD_LAST = BUD_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    // Budget tracked separately so a narrow, saturating cycles output cannot stall expiry.
    logic [BUD_W-1:0] budget;
    logic             tohost_hit;

    // Load path is combinational so each byte lands in RAM in its handshake cycle.
    assign ld_ready   = (state == S_LOAD) && (ptr < PTR_MAX);
    assign ram_we     = ld_valid && ld_ready;
    assign ram_addr   = ADDR_WIDTH'(ptr);
    assign ram_wdata  = ld_data;
    assign tohost_hit = mon_we && (mon_addr == TOHOST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            budget    <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            load_err  <= 1'b0;
            exit_code <= '0;
            cycles    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        ptr   <= '0;
                    end
                end

                S_LOAD: begin
                    if (ram_we) begin
                        ptr <= ptr + PTR_W'(1);
                        if (ld_last) begin
                            state <= S_RELEASE;
                        end
                    end else if (!ld_ready) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        load_err <= 1'b1;
                        pass     <= 1'b0;
                    end
                end

                S_RELEASE: begin
                    state   <= S_RUN;
                    cycles  <= '0;
                    budget  <= '0;
                    cpu_rst <= 1'b0;
                end

                S_RUN: begin
                    if (cycles != {CNT_WIDTH{1'b1}}) begin
                        cycles <= cycles + CNT_WIDTH'(1);
                    end
                    budget <= budget + BUD_W'(1);
                    // A tohost store wins over budget expiry in the same cycle.
                    if (tohost_hit) begin
                        exit_code <= mon_wdata;
                        pass      <= (mon_wdata == DATA_WIDTH'(1));
                        timeout   <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst   <= 1'b1;
                        state     <= S_DONE;
                    end else if (budget == BUD_LAST) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b1;
                        state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        ptr       <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        load_err  <= 1'b0;
                        exit_code <= '0;
                        cycles    <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rua_run_ctrl.sv
// Self-checking bench for rua_run_ctrl: scenario-level reference expectations checked every cycle,
// plus literal checks on directed load/run/finish sequences.
module tb_rua_run_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 8;
    localparam int unsigned MC = 100;
    localparam int unsigned CW = 32;
    localparam logic [31:0] TH = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          cpu_rst;
    logic          mon_we;
    logic [AW-1:0] mon_addr;
    logic [DW-1:0] mon_wdata;
    logic          done;
    logic          pass;
    logic          timeout;
    logic          load_err;
    logic [DW-1:0] exit_code;
    logic [CW-1:0] cycles;

    rua_run_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_BYTES  (MB),
        .MAX_CYCLES (MC),
        .TOHOST_ADDR(TH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .cpu_rst  (cpu_rst),
        .mon_we   (mon_we),
        .mon_addr (mon_addr),
        .mon_wdata(mon_wdata),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout),
        .load_err (load_err),
        .exit_code(exit_code),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs for the current cycle, set by the scenario driver.
    logic        e_ld_ready, e_ram_we, e_cpu_rst, e_done, e_pass, e_timeout, e_load_err;
    logic [31:0] e_ram_addr, e_exit, e_cycles;
    logic [7:0]  e_ram_wdata;
    bit          chk_en = 1'b0;

    logic [7:0]  img [4] = '{8'h13, 8'h00, 8'h00, 8'h00};

    // Write log and cpu_rst timing capture for the literal checks.
    logic [31:0] wq_addr [$];
    logic [7:0]  wq_data [$];
    int          cyc = 0;
    int          hs_cyc = 0;
    int          fall_cyc = 0;
    logic        prev_cpu_rst = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) begin
            wq_addr.push_back(ram_addr);
            wq_data.push_back(ram_wdata);
            if (ld_last) hs_cyc = cyc;
        end
        if (!cpu_rst && prev_cpu_rst) fall_cyc = cyc;
        prev_cpu_rst = cpu_rst;
    end

    // Per-cycle compare against the driver's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ld_ready", 64'(ld_ready), 64'(e_ld_ready));
            check("ram_we", 64'(ram_we), 64'(e_ram_we));
            if (e_ram_we) begin
                check("ram_addr", 64'(ram_addr), 64'(e_ram_addr));
                check("ram_wdata", 64'(ram_wdata), 64'(e_ram_wdata));
            end
            check("cpu_rst", 64'(cpu_rst), 64'(e_cpu_rst));
            check("done", 64'(done), 64'(e_done));
            check("pass", 64'(pass), 64'(e_pass));
            check("timeout", 64'(timeout), 64'(e_timeout));
            check("load_err", 64'(load_err), 64'(e_load_err));
            check("exit_code", 64'(exit_code), 64'(e_exit));
            check("cycles", 64'(cycles), 64'(e_cycles));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset();
        e_ld_ready = 1'b0; e_ram_we = 1'b0; e_cpu_rst = 1'b1;
        e_done = 1'b0; e_pass = 1'b0; e_timeout = 1'b0; e_load_err = 1'b0;
        e_exit = '0; e_cycles = '0; e_ram_addr = '0; e_ram_wdata = '0;
    endtask

    // Stay in DONE with noisy inputs; nothing may change.
    task automatic hold_done();
        int n;
        n = 2 + int'($urandom_range(2));
        e_ld_ready = 1'b0;
        e_ram_we   = 1'b0;
        for (int h = 0; h < n; h++) begin
            start     = 1'b0;
            ld_valid  = 1'($urandom);
            ld_data   = 8'($urandom);
            ld_last   = 1'b0;
            mon_we    = 1'($urandom);
            mon_addr  = TH;
            mon_wdata = $urandom;
            step();
        end
        mon_we   = 1'b0;
        ld_valid = 1'b0;
    endtask

    // One start/load/run/finish sequence; expectations derived from the scenario arguments.
    task automatic run(input int nbytes, input bit with_last, input int store_at,
                       input logic [31:0] store_val, input int rst_at, input int gap_pct,
                       input bit fixed);
        int wr;
        int t_end;
        bit stored;
        wq_addr.delete();
        wq_data.delete();

        start    = 1'b1;
        ld_valid = 1'($urandom);
        ld_data  = 8'($urandom);
        ld_last  = 1'b0;
        mon_we   = 1'b0;
        e_ld_ready = 1'b0;
        e_ram_we   = 1'b0;
        step();

        start = 1'b0;
        e_done = 1'b0; e_pass = 1'b0; e_timeout = 1'b0; e_load_err = 1'b0;
        e_exit = '0; e_cycles = '0; e_cpu_rst = 1'b1;
        wr = 0;
        forever begin
            if (wr == int'(MB)) begin
                ld_valid = 1'b1;
                ld_data  = 8'($urandom);
                ld_last  = 1'b0;
                start    = 1'b0;
                e_ld_ready = 1'b0;
                e_ram_we   = 1'b0;
                step();
                e_done     = 1'b1;
                e_load_err = 1'b1;
                ld_valid   = 1'b0;
                hold_done();
                return;
            end
            ld_valid = ($urandom_range(99) >= 32'(gap_pct));
            ld_data  = fixed ? img[wr % 4] : 8'($urandom);
            ld_last  = with_last && (wr == nbytes - 1);
            start    = ($urandom_range(3) == 0);
            e_ld_ready  = 1'b1;
            e_ram_we    = ld_valid;
            e_ram_addr  = 32'(wr);
            e_ram_wdata = ld_data;
            step();
            if (ld_valid) begin
                wr++;
                if (ld_last) break;
            end
        end

        // Release cycle: core still in reset, loader and monitor ignored.
        start     = 1'b0;
        ld_last   = 1'b0;
        ld_valid  = 1'($urandom);
        mon_we    = 1'($urandom);
        mon_addr  = TH;
        mon_wdata = $urandom;
        e_ld_ready = 1'b0;
        e_ram_we   = 1'b0;
        step();

        t_end  = (store_at >= 1 && store_at <= int'(MC)) ? store_at : int'(MC);
        stored = (t_end == store_at);
        for (int k = 1; k <= t_end; k++) begin
            e_cpu_rst = 1'b0;
            e_cycles  = 32'(k - 1);
            ld_valid  = 1'($urandom);
            start     = 1'($urandom);
            if (k == store_at) begin
                mon_we = 1'b1; mon_addr = TH; mon_wdata = store_val;
            end else if (k == 5) begin
                mon_we = 1'b1; mon_addr = TH - 32'd4; mon_wdata = 32'd5;
            end else begin
                mon_we    = 1'($urandom);
                mon_addr  = ($urandom_range(1) == 1) ? TH + 32'($urandom_range(1, 64))
                                                     : TH - 32'($urandom_range(1, 64));
                mon_wdata = $urandom;
            end
            if (k == rst_at) rst = 1'b1;
            step();
            if (rst) begin
                rst = 1'b0; mon_we = 1'b0; ld_valid = 1'b0; start = 1'b0;
                expect_reset();
                step();
                return;
            end
        end

        start  = 1'b0;
        mon_we = 1'b0;
        e_done    = 1'b1;
        e_cpu_rst = 1'b1;
        e_cycles  = 32'(t_end);
        if (stored) begin
            e_exit = store_val; e_pass = (store_val == 32'd1); e_timeout = 1'b0;
        end else begin
            e_exit = '0; e_pass = 1'b0; e_timeout = 1'b1;
        end
        hold_done();
    endtask

    initial begin
        int nb;
        int sa;
        int ra;
        bit ov;
        logic [31:0] sv;

        rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        mon_we = 1'b0; mon_addr = '0; mon_wdata = '0;
        @(posedge clk);
        #1;
        expect_reset();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Pass run: 4-byte image, tohost=1 on 7th RUN cycle.
        run(4, 1'b1, 7, 32'd1, 0, 0, 1'b1);
        check("lit_nwrites", 64'(wq_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq_addr.size()) begin
                check("lit_wr_addr", 64'(wq_addr[i]), 64'(i));
                check("lit_wr_data", 64'(wq_data[i]), 64'(img[i]));
            end
        end
        check("lit_rst_fall_delay", 64'(fall_cyc - hs_cyc), 64'd2);
        check("lit_pass", 64'(pass), 64'd1);
        check("lit_exit", 64'(exit_code), 64'd1);
        check("lit_cycles7", 64'(cycles), 64'd7);
        check("lit_timeout0", 64'(timeout), 64'd0);

        // Timeout run: no tohost store.
        run(4, 1'b1, 0, 32'd0, 0, 0, 1'b1);
        check("lit_to_timeout", 64'(timeout), 64'd1);
        check("lit_to_pass", 64'(pass), 64'd0);
        check("lit_to_cycles", 64'(cycles), 64'd100);
        check("lit_to_cpu_rst", 64'(cpu_rst), 64'd1);

        // Tohost store coincides with budget expiry.
        run(4, 1'b1, 100, 32'd7, 0, 0, 1'b1);
        check("lit_tie_timeout", 64'(timeout), 64'd0);
        check("lit_tie_pass", 64'(pass), 64'd0);
        check("lit_tie_exit", 64'(exit_code), 64'd7);
        check("lit_tie_cycles", 64'(cycles), 64'd100);

        // Image overflow: 9 bytes, no last.
        run(9, 1'b0, 0, 32'd0, 0, 0, 1'b0);
        check("lit_ovf_nwrites", 64'(wq_addr.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wq_addr.size()) check("lit_ovf_addr", 64'(wq_addr[i]), 64'(i));
        end
        check("lit_ovf_load_err", 64'(load_err), 64'd1);
        check("lit_ovf_done", 64'(done), 64'd1);
        check("lit_ovf_cpu_rst", 64'(cpu_rst), 64'd1);

        // Gappy valid: addresses stay contiguous.
        run(3, 1'b1, 2, 32'd3, 0, 50, 1'b0);
        check("lit_gap_nwrites", 64'(wq_addr.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wq_addr.size()) check("lit_gap_addr", 64'(wq_addr[i]), 64'(i));
        end

        // Reset on 3rd RUN cycle, then reload from IDLE, then rerun from DONE.
        run(4, 1'b1, 0, 32'd0, 3, 0, 1'b1);
        check("lit_rst_done", 64'(done), 64'd0);
        check("lit_rst_cycles", 64'(cycles), 64'd0);
        check("lit_rst_cpu_rst", 64'(cpu_rst), 64'd1);
        run(2, 1'b1, 1, 32'd1, 0, 0, 1'b0);
        check("lit_re_pass", 64'(pass), 64'd1);
        check("lit_re_cycles", 64'(cycles), 64'd1);
        run(4, 1'b1, 10, 32'd0, 0, 20, 1'b0);
        check("lit_rerun_pass", 64'(pass), 64'd0);
        check("lit_rerun_exit", 64'(exit_code), 64'd0);
        check("lit_rerun_cycles", 64'(cycles), 64'd10);

        // Randomized scenarios.
        for (int s = 0; s < 30; s++) begin
            ov = ($urandom_range(5) == 0);
            nb = int'($urandom_range(1, MB));
            sa = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(1, 110));
            ra = ($urandom_range(7) == 0) ? int'($urandom_range(1, 20)) : 0;
            sv = ($urandom_range(2) == 0) ? 32'd1 : $urandom;
            run(ov ? int'(MB) + 1 : nb, !ov, sa, sv, ra, int'($urandom_range(0, 60)), 1'b0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rua_run_ctrl.md
Name: rua_run_ctrl

Overview:
- Synthesizable run controller that holds the rua core in reset and streams a byte-wise program image into RAM.
- It then releases the core and counts execution cycles until the core stores to a tohost address or a cycle budget expires.
- It latches pass/fail, exit code and cycle count, so benches and FPGA top levels share one load/run/finish sequence instead of hand-coded hierarchical memory loads and fixed-length loops.

Parameters:
ADDR_WIDTH, 32, width of RAM byte address and monitored store address
DATA_WIDTH, 32, width of monitored store data and exit_code
MEM_BYTES, 5300, RAM capacity in bytes; load pointer limit
MAX_CYCLES, 100, run budget in core cycles before timeout
TOHOST_ADDR, 32'h0000_1000, store address that terminates the run
CNT_WIDTH, 32, width of cycle counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: begin load (honoured in IDLE or DONE only)
ld_valid  input  1  program byte offered
ld_data  input  8  program byte
ld_last  input  1  marks final byte of image
ld_ready  output  1  controller accepts byte
ram_we  output  1  RAM byte write enable
ram_addr  output  ADDR_WIDTH  RAM byte address
ram_wdata  output  8  RAM byte data
cpu_rst  output  1  reset to rua core
mon_we  input  1  core data-store strobe
mon_addr  input  ADDR_WIDTH  core store address
mon_wdata  input  DATA_WIDTH  core store data
done  output  1  run finished (sticky)
pass  output  1  exit code == 1
timeout  output  1  budget exhausted
load_err  output  1  image exceeded MEM_BYTES
exit_code  output  DATA_WIDTH  value stored to TOHOST_ADDR
cycles  output  CNT_WIDTH  RUN cycles elapsed

Behaviour:
- Reset (rst=1 at posedge, any state): state=IDLE, load pointer=0; cpu_rst=1; all other registered outputs 0. Reset mid-LOAD or mid-RUN aborts the operation with no partial flags.
- States: IDLE, LOAD, RELEASE, RUN, DONE. cpu_rst=1 in every state except RUN.
- IDLE:
  - ld_ready=0.
  - start -> LOAD, pointer=0.
- LOAD:
  - ld_ready=1 while pointer<MEM_BYTES.
  - Combinational write path: ram_we = ld_valid & ld_ready, ram_addr = pointer, ram_wdata = ld_data, so a byte is written in its handshake cycle.
  - Each accepted beat increments pointer.
  - Accepted beat with ld_last=1 -> RELEASE next cycle.
  - pointer==MEM_BYTES without last seen: ld_ready=0, offered beat dropped, next state DONE with load_err=1, done=1, pass=0.
- RELEASE: one cycle; cycles cleared to 0; -> RUN. Gives the core one clean reset edge after the last write.
- RUN:
  - cpu_rst=0; cycles increments at every RUN posedge, including the terminating one.
  - Terminate on mon_we=1 with mon_addr==TOHOST_ADDR: exit_code=mon_wdata, pass=(mon_wdata==1), -> DONE.
  - Otherwise, if cycles==MAX_CYCLES-1: timeout=1, pass=0, -> DONE. The held cycles value is then MAX_CYCLES.
  - Tohost store and budget expiry in the same cycle: tohost wins, timeout=0.
  - Stores to other addresses are ignored.
- DONE:
  - done=1; pass, timeout, load_err, exit_code and cycles hold until rst or start.
  - start clears all flags, exit_code and cycles, and -> LOAD (rerun without rst).
- start in LOAD, RELEASE or RUN is ignored.
- cycles saturates at all-ones; it never wraps when CNT_WIDTH is smaller than log2(MAX_CYCLES).
- ld_valid/ld_data outside LOAD have no effect; ram_we=0 outside LOAD.

Test Plan:
- Load 4 bytes 13,00,00,00 (last on 4th) -> ram_we pulses at addresses 0..3 with those bytes. cpu_rst falls 2 cycles after the last handshake. Core stores 1 to 0x1000 on its 7th RUN cycle -> done=1, pass=1, exit_code=1, cycles=7, timeout=0.
- Same load; core never stores to tohost, MAX_CYCLES=100 -> after the 100th RUN cycle: done=1, timeout=1, pass=0, cycles=100, cpu_rst=1.
- Core stores 0x0000_0007 to 0x1000 in the same cycle as budget expiry -> timeout=0, pass=0, exit_code=7, cycles=100. A store of 5 to 0x0FFC earlier is ignored.
- MEM_BYTES=8, stream 9 bytes with no ld_last -> 8 writes at addresses 0..7; ld_ready drops with 9th offered -> load_err=1, done=1, cpu_rst stays 1, 9th byte never written.
- ld_valid held with gaps, i.e. 1,0,1,1 -> pointer advances only on handshake cycles; addresses contiguous 0,1,2.
- rst asserted on 3rd RUN cycle -> next cycle IDLE, cpu_rst=1, done=0, cycles=0. Then start plus a new load; also a start pulse in DONE reruns the load and clears pass, exit_code and cycles.
